cic_decimator_stage: RTL and testbench

//   Rate-change stage of the CIC decimator: sits between the integrator chain and the comb chain.

---
 rtl/cic_decimator_stage_pkg.sv | 11 +
 rtl/cic_decimator_stage_if.sv | 25 ++
 rtl/cic_decimator_stage_rate_ctrl.sv | 51 +++++
 rtl/cic_decimator_stage.sv | 73 +++++++
 tb/tb_cic_decimator_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_decimator_stage_pkg.sv
// Shared CIC constants and helpers used by the integrator, decimator and comb blocks.
package cic_pkg;

    localparam int CIC_DEFAULT_WIDTH = 16;
    localparam int CIC_DEFAULT_R_MAX = 16;

    function automatic bit rate_legal(input int unsigned rate, input int unsigned r_max);
        return (rate >= 1) && (rate <= r_max);
    endfunction

endpackage

// File: rtl/cic_decimator_stage_if.sv
// Sample stream into and out of the decimation stage: integrator side and comb side.
interface cic_decimator_stage_if
    import cic_pkg::*;
#(
    parameter int WIDTH = CIC_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/cic_decimator_stage_rate_ctrl.sv
// Decimation rate register, sticky rate error and frame phase counter.
module cic_rate_ctrl
    import cic_pkg::*;
#(
    parameter int R_MAX   = CIC_DEFAULT_R_MAX,
    parameter int RATE_W  = $clog2(R_MAX + 1),
    parameter int PHASE_W = (R_MAX > 1) ? $clog2(R_MAX) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATE_W-1:0]  cfg_rate,
    input  logic               cfg_load,
    input  logic               accept,
    output logic [PHASE_W-1:0] phase,
    output logic               last,
    output logic               rate_err
);

    logic [RATE_W-1:0]  rate_q;
    logic [PHASE_W-1:0] phase_q;
    logic               err_q;
    logic               load_ok;
    logic [RATE_W-1:0]  phase_ext;

    assign load_ok   = rate_legal(32'(cfg_rate), 32'(R_MAX));
    assign phase_ext = RATE_W'(phase_q);
    assign last      = (phase_ext == rate_q - RATE_W'(1));

    // An illegal load only flags the error; the running frame continues untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q  <= RATE_W'(R_MAX);
            phase_q <= '0;
            err_q   <= 1'b0;
        end else if (cfg_load) begin
            if (load_ok) begin
                rate_q  <= cfg_rate;
                phase_q <= '0;
                err_q   <= 1'b0;
            end else begin
                err_q   <= 1'b1;
            end
        end else if (accept) begin
            phase_q <= last ? '0 : phase_q + PHASE_W'(1);
        end
    end

    assign phase    = phase_q;
    assign rate_err = err_q;

endmodule

// File: rtl/cic_decimator_stage.sv
// Rate-change stage between integrators and combs: forwards every R-th accepted sample
// through a one-entry output register with valid/ready flow control.
module cic_decimator_stage
    import cic_pkg::*;
#(
    parameter int  WIDTH   = CIC_DEFAULT_WIDTH,
    parameter int  R_MAX   = CIC_DEFAULT_R_MAX,
    localparam int RATE_W  = $clog2(R_MAX + 1),
    localparam int PHASE_W = (R_MAX > 1) ? $clog2(R_MAX) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RATE_W-1:0]   cfg_rate,
    input  logic                cfg_load,
    output logic                rate_err,
    cic_decimator_stage_if.slave bus,
    output logic [PHASE_W-1:0]  phase
);

    logic             accept;
    logic             last;
    logic             capture;
    logic             pop;
    logic             in_ready;
    logic [WIDTH-1:0] data_p0;
    logic             vld_p0;

    // Only the frame-closing sample needs the output slot, so stall just that one.
    assign in_ready = !cfg_load && !(last && vld_p0 && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign capture  = accept && last;
    assign pop      = vld_p0 && bus.out_ready;

    cic_rate_ctrl #(
        .R_MAX   (R_MAX),
        .RATE_W  (RATE_W),
        .PHASE_W (PHASE_W)
    ) u_rate_ctrl (
        .clk      (clk),
        .rst      (rst),
        .cfg_rate (cfg_rate),
        .cfg_load (cfg_load),
        .accept   (accept),
        .phase    (phase),
        .last     (last),
        .rate_err (rate_err)
    );

    // Stage p0: output register toward the comb chain
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (capture) begin
            vld_p0  <= 1'b1;
            data_p0 <= bus.in_data;
        end else if (pop) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_p0;
    assign bus.out_valid = vld_p0;

`ifdef CIC_DECIMATOR_STAGE_SVA
    stall_hold: assert property (@(posedge clk) disable iff (rst)
        (vld_p0 && !bus.out_ready) |=> (vld_p0 && $stable(data_p0)));
    no_overwrite: assert property (@(posedge clk) disable iff (rst)
        !(capture && vld_p0 && !bus.out_ready));
`endif

endmodule

// File: tb/tb_cic_decimator_stage.sv
// Bench for cic_decimator_stage: directed frames, a config-load table and random traffic
// checked against a count-and-queue reference model.
module tb_cic_decimator_stage;

    localparam int W  = 8;
    localparam int RM = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cfg_rate;
    logic       cfg_load;
    logic       rate_err;
    logic [2:0] phase;

    cic_decimator_stage_if #(.WIDTH(W)) bus ();

    cic_decimator_stage #(.WIDTH(W), .R_MAX(RM)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_rate (cfg_rate),
        .cfg_load (cfg_load),
        .rate_err (rate_err),
        .bus      (bus),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: active rate, samples accepted in the frame, outputs not yet taken.
    int         m_rate = RM;
    int         m_cnt  = 0;
    bit         m_err  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];

    logic       s_rdy, s_vld, s_err;
    logic [7:0] s_data;
    logic [2:0] s_phase;
    logic [7:0] dcnt = 8'd0;

    typedef struct {
        logic [3:0] rate;
        bit         err;
        int         ph;
        int         outs;
    } cfg_vec_t;
    cfg_vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic ordy,
                         input logic ld, input logic [3:0] r, input logic rs);
        logic       exp_rdy;
        logic [7:0] tmp;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        cfg_load      = ld;
        cfg_rate      = r;
        rst           = rs;
        #1;
        s_rdy   = bus.in_ready;
        s_vld   = bus.out_valid;
        s_data  = bus.out_data;
        s_err   = rate_err;
        s_phase = phase;
        exp_rdy = !ld && !((m_cnt == m_rate - 1) && (exp_q.size() != 0) && !ordy);
        chk("in_ready", 32'(s_rdy), 32'(exp_rdy));
        chk("phase", 32'(s_phase), 32'(m_cnt));
        chk("rate_err", 32'(s_err), 32'(m_err));
        chk("out_valid", 32'(s_vld), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_data", 32'(s_data), 32'(exp_q[0]));
        if (s_vld && ordy) got.push_back(s_data);
        if (exp_q.size() != 0 && ordy) tmp = exp_q.pop_front();
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            m_cnt  = 0;
            m_rate = RM;
            m_err  = 1'b0;
        end else if (ld) begin
            if (int'(r) >= 1 && int'(r) <= RM) begin
                m_rate = int'(r);
                m_cnt  = 0;
                m_err  = 1'b0;
            end else begin
                m_err  = 1'b1;
            end
        end else if (v && exp_rdy) begin
            m_cnt++;
            if (m_cnt == m_rate) begin
                exp_q.push_back(d);
                m_cnt = 0;
            end
        end
    endtask

    task automatic feed(input logic [7:0] d, input logic ordy);
        cycle(1'b1, d, ordy, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [3:0] r);
        cycle(1'b0, 8'd0, 1'b1, 1'b1, r, 1'b0);
    endtask

    initial begin
        int n0;
        tbl[0] = '{rate: 4'd3,  err: 1'b0, ph: 0, outs: 4};
        tbl[1] = '{rate: 4'd0,  err: 1'b1, ph: 1, outs: 4};
        tbl[2] = '{rate: 4'd9,  err: 1'b1, ph: 2, outs: 4};
        tbl[3] = '{rate: 4'd5,  err: 1'b0, ph: 0, outs: 2};
        tbl[4] = '{rate: 4'd1,  err: 1'b0, ph: 0, outs: 12};
        tbl[5] = '{rate: 4'd15, err: 1'b1, ph: 0, outs: 12};
        tbl[6] = '{rate: 4'd8,  err: 1'b0, ph: 0, outs: 1};
        tbl[7] = '{rate: 4'd4,  err: 1'b0, ph: 0, outs: 3};

        rst = 1'b1; cfg_load = 1'b0; cfg_rate = 4'd0;
        bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b1;

        // Reset state and default rate of 8
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b1);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b1);
        idle(1);
        chk("rst_out_valid", 32'(s_vld), 32'd0);
        chk("rst_out_data", 32'(s_data), 32'd0);
        chk("rst_phase", 32'(s_phase), 32'd0);
        chk("rst_rate_err", 32'(s_err), 32'd0);
        got.delete();
        for (int i = 0; i < 16; i++) feed(8'(i), 1'b1);
        idle(2);
        chk("t1_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t1_out0", 32'(got[0]), 32'd7);
            chk("t1_out1", 32'(got[1]), 32'd15);
        end

        // Config-load table: one sample, load, then 12 samples at full rate
        for (int i = 0; i < 8; i++) begin
            feed(dcnt, 1'b1); dcnt++;
            load(tbl[i].rate);
            n0 = got.size();
            feed(dcnt, 1'b1); dcnt++;
            chk("tbl_err", 32'(s_err), 32'(tbl[i].err));
            chk("tbl_phase", 32'(s_phase), 32'(tbl[i].ph));
            for (int k = 0; k < 11; k++) begin feed(dcnt, 1'b1); dcnt++; end
            idle(2);
            chk("tbl_outs", 32'(got.size() - n0), 32'(tbl[i].outs));
        end

        // Rate 3
        load(4'd3);
        got.delete();
        for (int i = 1; i <= 9; i++) feed(8'(i), 1'b1);
        idle(2);
        chk("t2_rate_err", 32'(s_err), 32'd0);
        chk("t2_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t2_out0", 32'(got[0]), 32'd3);
            chk("t2_out1", 32'(got[1]), 32'd6);
            chk("t2_out2", 32'(got[2]), 32'd9);
        end

        // Backpressure at rate 2: sample 4 must wait behind pending 2
        load(4'd2);
        got.delete();
        feed(8'd1, 1'b0);
        feed(8'd2, 1'b0);
        feed(8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            feed(8'd4, 1'b0);
            chk("t3_stall_ready", 32'(s_rdy), 32'd0);
            chk("t3_stall_valid", 32'(s_vld), 32'd1);
            chk("t3_stall_data", 32'(s_data), 32'd2);
        end
        feed(8'd4, 1'b1);
        feed(8'd5, 1'b1);
        idle(2);
        chk("t3_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t3_out0", 32'(got[0]), 32'd2);
            chk("t3_out1", 32'(got[1]), 32'd4);
        end

        // Rate 1 pass-through with a stall and simultaneous pop + capture
        load(4'd1);
        got.delete();
        feed(8'd10, 1'b1);
        feed(8'd11, 1'b0);
        chk("t5_stall_ready", 32'(s_rdy), 32'd0);
        feed(8'd11, 1'b1);
        feed(8'd12, 1'b1);
        chk("t5_keep_valid", 32'(s_vld), 32'd1);
        chk("t5_keep_data", 32'(s_data), 32'd11);
        idle(2);
        chk("t5_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t5_out0", 32'(got[0]), 32'd10);
            chk("t5_out1", 32'(got[1]), 32'd11);
            chk("t5_out2", 32'(got[2]), 32'd12);
        end

        // Mid-frame reset with an output pending
        load(4'd4);
        for (int i = 20; i < 26; i++) feed(8'(i), 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t6_out_valid", 32'(s_vld), 32'd0);
        chk("t6_out_data", 32'(s_data), 32'd0);
        chk("t6_phase", 32'(s_phase), 32'd0);
        got.delete();
        for (int i = 30; i < 38; i++) feed(8'(i), 1'b1);
        idle(2);
        chk("t6_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("t6_out0", 32'(got[0]), 32'd37);

        // Random traffic, loads and occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 399) == 0);
        end
        idle(3);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
